// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - multi-digit BCD up/down counter with clear, validated load and wrap/saturate
// Digit carries/borrows are derived from per-digit 9/0 flags so the chain has no self-referencing net.
module bcd_updown_counter #(
  parameter int NUM  = 3,
  parameter bit WRAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [4*NUM-1:0] load_val,
  input  logic             din_vld,
  input  logic             dir,
  output logic [4*NUM-1:0] dout,
  output logic             dout_vld,
  output logic             ovf,
  output logic             load_err
);

  logic [NUM-1:0]   is9;
  logic [NUM-1:0]   is0;
  logic [NUM-1:0]   up_step;
  logic [NUM-1:0]   dn_step;
  logic [NUM-1:0]   ld_ok;
  logic [4*NUM-1:0] nxt_up;
  logic [4*NUM-1:0] nxt_dn;
  logic             all9;
  logic             all0;
  logic             load_good;

  genvar i;
  generate
    for (i = 0; i < NUM; i++) begin : g_digit
      logic [3:0] d;
      assign d        = dout[4*i +: 4];
      assign is9[i]   = (d == 4'd9);
      assign is0[i]   = (d == 4'd0);
      assign ld_ok[i] = (load_val[4*i +: 4] <= 4'd9);

      if (i == 0) begin : g_lsd
        assign up_step[i] = 1'b1;
        assign dn_step[i] = 1'b1;
      end else begin : g_upper
        // A digit moves only when every lower digit sits at its rollover value.
        assign up_step[i] = &is9[i-1:0];
        assign dn_step[i] = &is0[i-1:0];
      end

      assign nxt_up[4*i +: 4] = !up_step[i] ? d : (is9[i] ? 4'd0 : d + 4'd1);
      assign nxt_dn[4*i +: 4] = !dn_step[i] ? d : (is0[i] ? 4'd9 : d - 4'd1);
    end
  endgenerate

  assign all9      = &is9;
  assign all0      = &is0;
  assign load_good = &ld_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        dout     <= '0;
        dout_vld <= 1'b1;
      end else if (load) begin
        if (load_good) begin
          dout     <= load_val;
          dout_vld <= 1'b1;
        end else begin
          load_err <= 1'b1;
        end
      end else if (din_vld) begin
        dout_vld <= 1'b1;
        // At a boundary the chain result already equals the wrapped value; saturation just holds.
        if (dir) begin
          ovf <= all9;
          if (!all9 || WRAP) dout <= nxt_up;
        end else begin
          ovf <= all0;
          if (!all0 || WRAP) dout <= nxt_dn;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - directed self-checking bench for bcd_updown_counter
// Wrap and saturate variants share one stimulus stream.
module tb_bcd_updown_counter;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        load;
  logic [11:0] load_val;
  logic        din_vld;
  logic        dir;
  logic [11:0] w_dout, s_dout;
  logic        w_vld, s_vld, w_ovf, s_ovf, w_err, s_err;

  int n_assert = 0;
  int n_fail   = 0;

  bcd_updown_counter #(.NUM(3), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .din_vld(din_vld), .dir(dir), .dout(w_dout), .dout_vld(w_vld),
    .ovf(w_ovf), .load_err(w_err)
  );

  bcd_updown_counter #(.NUM(3), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .din_vld(din_vld), .dir(dir), .dout(s_dout), .dout_vld(s_vld),
    .ovf(s_ovf), .load_err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_w(input string tag, input logic [11:0] d, input logic v, input logic o, input logic e);
    chk({tag, "_w_dout"}, {20'd0, w_dout}, {20'd0, d});
    chk({tag, "_w_vld"},  {31'd0, w_vld},  {31'd0, v});
    chk({tag, "_w_ovf"},  {31'd0, w_ovf},  {31'd0, o});
    chk({tag, "_w_err"},  {31'd0, w_err},  {31'd0, e});
  endtask

  task automatic chk_s(input string tag, input logic [11:0] d, input logic v, input logic o, input logic e);
    chk({tag, "_s_dout"}, {20'd0, s_dout}, {20'd0, d});
    chk({tag, "_s_vld"},  {31'd0, s_vld},  {31'd0, v});
    chk({tag, "_s_ovf"},  {31'd0, s_ovf},  {31'd0, o});
    chk({tag, "_s_err"},  {31'd0, s_err},  {31'd0, e});
  endtask

  task automatic do_load(input logic [11:0] v);
    load = 1'b1; load_val = v; din_vld = 1'b0;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; din_vld = 1'b0; dir = 1'b1;

    // Reset then idle
    cyc(); chk_w("rst0", 12'h000, 0, 0, 0); chk_s("rst0", 12'h000, 0, 0, 0);
    cyc(); chk_w("rst1", 12'h000, 0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(); chk_w("idle", 12'h000, 0, 0, 0); chk_s("idle", 12'h000, 0, 0, 0);
    end

    // Up carry chain and wrap
    do_load(12'h098); chk_w("ld098", 12'h098, 1, 0, 0);
    din_vld = 1'b1; dir = 1'b1;
    cyc(); chk_w("up099", 12'h099, 1, 0, 0);
    cyc(); chk_w("up100", 12'h100, 1, 0, 0);
    cyc(); chk_w("up101", 12'h101, 1, 0, 0);
    din_vld = 1'b0;
    do_load(12'h999); chk_w("ld999", 12'h999, 1, 0, 0); chk_s("ld999", 12'h999, 1, 0, 0);
    din_vld = 1'b1; dir = 1'b1;
    cyc(); chk_w("wrap_up", 12'h000, 1, 1, 0); chk_s("sat_up", 12'h999, 1, 1, 0);
    din_vld = 1'b0;
    cyc(); chk_w("hold", 12'h000, 0, 0, 0); chk_s("hold", 12'h999, 0, 0, 0);

    // Borrow chain
    do_load(12'h100);
    din_vld = 1'b1; dir = 1'b0;
    cyc(); chk_w("dn099", 12'h099, 1, 0, 0); chk_s("dn099", 12'h099, 1, 0, 0);
    din_vld = 1'b0;

    // Saturate / wrap at zero going down
    do_load(12'h001);
    din_vld = 1'b1; dir = 1'b0;
    cyc(); chk_s("dn1", 12'h000, 1, 0, 0); chk_w("dn1", 12'h000, 1, 0, 0);
    cyc(); chk_s("dn2", 12'h000, 1, 1, 0); chk_w("dn2", 12'h999, 1, 1, 0);
    cyc(); chk_s("dn3", 12'h000, 1, 1, 0); chk_w("dn3", 12'h998, 1, 0, 0);
    din_vld = 1'b0;

    // Load validation, with din_vld ignored on a rejected load
    load = 1'b1; load_val = 12'h1A3; din_vld = 1'b1; dir = 1'b1;
    cyc(); chk_s("badld", 12'h000, 0, 0, 1); chk_w("badld", 12'h998, 0, 0, 1);
    load_val = 12'h456; din_vld = 1'b0;
    cyc(); chk_s("ld456", 12'h456, 1, 0, 0); chk_w("ld456", 12'h456, 1, 0, 0);
    load = 1'b0;

    // Priority
    clr = 1'b1; load = 1'b1; load_val = 12'h777; din_vld = 1'b1; dir = 1'b1;
    cyc(); chk_w("prio_clr", 12'h000, 1, 0, 0); chk_s("prio_clr", 12'h000, 1, 0, 0);
    clr = 1'b0; load_val = 12'h123;
    cyc(); chk_w("prio_ld", 12'h123, 1, 0, 0);
    load = 1'b0; din_vld = 1'b0;

    // Reset mid-count
    clr = 1'b1;
    cyc(); chk_w("clr", 12'h000, 1, 0, 0);
    clr = 1'b0; din_vld = 1'b1; dir = 1'b1;
    for (int k = 0; k < 7; k++) cyc();
    chk_w("cnt7", 12'h007, 1, 0, 0);
    rst = 1'b1;
    cyc(); chk_w("midrst", 12'h000, 0, 0, 0); chk_s("midrst", 12'h000, 0, 0, 0);
    rst = 1'b0;
    cyc(); chk_w("resume1", 12'h001, 1, 0, 0);
    cyc(); chk_w("resume2", 12'h002, 1, 0, 0);
    din_vld = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD counter. Successor to the single-direction decimal increment counter.
- Adds an up/down direction, a synchronous clear, and a parallel BCD load with digit validation.
- Adds a selectable wrap or saturate mode and a registered overflow/underflow pulse.
- Drives digit displays and event tallies in key/scan and display datapaths; the output feeds seven-segment decoders directly.

Parameters:
- NUM, 3: number of BCD digits; legal range 1..8; dout width is 4*NUM.
- WRAP, 1: 1 = wrap at the boundaries (99..9 -> 0, 0 -> 99..9); 0 = saturate at the boundaries.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- clr  input  1  synchronous clear of the count to 0.
- load  input  1  parallel load strobe.
- load_val  input  4*NUM  BCD load value; digit i is at [4i+3:4i]; digit 0 is least significant.
- din_vld  input  1  count enable; one step per cycle while high.
- dir  input  1  1 = count up, 0 = count down; sampled only when din_vld=1.
- dout  output  4*NUM  current BCD count; registered.
- dout_vld  output  1  high the cycle after dout was updated by a count, clear or accepted load.
- ovf  output  1  one-cycle pulse on an up-step from all-9s or a down-step from 0.
- load_err  output  1  one-cycle pulse when a load was rejected.

Behaviour:
- Reset: while rst=1 at a clock edge, dout=0, dout_vld=0, ovf=0, load_err=0. Reset overrides all other inputs, including mid-operation.
- Priority per cycle, highest first: rst > clr > load > din_vld. Lower-priority requests in the same cycle are dropped; there is no queuing.
- Clear:
  - clr=1 -> dout=0 next cycle, dout_vld=1, ovf=0.
  - A simultaneous load or din_vld is ignored and raises no error.
- Load:
  - load=1 and every digit of load_val is <= 9 -> dout=load_val next cycle, dout_vld=1.
  - Any digit > 9 -> dout unchanged, load_err=1 for one cycle, dout_vld=0.
  - Any din_vld in the same cycle is ignored in both cases.
- Up count (din_vld=1, dir=1), digit-serial carry chain:
  - Digit 0 always steps.
  - Digit i steps iff all lower digits are 9.
  - A stepping digit at 9 becomes 0; otherwise it increments by 1.
- Down count (din_vld=1, dir=0), borrow chain:
  - Digit i steps iff all lower digits are 0.
  - A stepping digit at 0 becomes 9; otherwise it decrements by 1.
- Boundaries:
  - Up from all-9s: WRAP=1 -> dout=0; WRAP=0 -> dout stays all-9s. ovf=1 in both modes.
  - Down from 0: WRAP=1 -> dout=all-9s; WRAP=0 -> dout stays 0. ovf=1 in both modes.
- Timing:
  - Latency from a request to the updated dout is one cycle.
  - dout_vld and ovf align with the new dout value.
  - dout_vld is high even when saturation leaves the value unchanged.
- Idle: with din_vld=0 and no clr or load, dout holds and all pulse outputs are 0.
- dout never contains a non-BCD digit.
- All outputs are registered; there is no combinational path from any input to any output.
- The next-state logic is a generate loop over NUM digits; no fixed-width assumptions beyond NUM.

Test Plan (NUM=3 unless stated):
- Reset/idle: rst=1 for 2 cycles, then din_vld=0 for 5 cycles -> dout=000, dout_vld=0, ovf=0 throughout.
- Up carry and wrap (WRAP=1): load 098, then 3 cycles of din_vld=1, dir=1 -> dout 099, 100, 101.
  - Then load 999 and step once -> dout=000, ovf=1 for one cycle.
- Saturate (WRAP=0): load 001, then 3 down-steps -> dout 000, 000, 000.
  - ovf=1 on the 2nd and 3rd steps; dout_vld=1 on all three.
- Load validation: load_val=0x1A3 -> load_err=1, dout unchanged.
  - Then load_val=0x456 -> dout=456, load_err=0.
- Priority: clr=1, load=1 (0x777) and din_vld=1 in the same cycle -> dout=000.
  - Then load=1 with din_vld=1, dir=1, load_val=0x123 -> dout=123, not 124.
- Reset mid-count: count up from 000 for 7 cycles, assert rst for 1 cycle -> dout=000 and dout_vld=0 on the next edge.
  - Counting resumes from 000 after rst deasserts.
